// File: rtl/ahbl_apb_bridge_if.sv
// Bus bundle between an AHB-Lite splitter port and the APB4 segment it feeds.
// The bridge connects through the "slave" modport: it is the AHB-Lite slave
// and the APB requester. The "master" modport is the opposite side, which
// drives the AHB request and answers on APB.
interface ahbl_apb_bridge_if;
    // AHB-Lite request/response
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    // APB4 request/completion
    logic [15:0] PSEL;
    logic        PENABLE;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA,
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB,
        input  PREADY, PRDATA, PSLVERR
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA,
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/ahbl_apb_bridge.sv
// AHB-Lite slave to APB4 bridge. Every accepted AHB transfer becomes one
// APB SETUP/ACCESS pair; the AHB response is decoded from registered state,
// and an ACCESS phase that never sees PREADY is aborted with an error.
module ahbl_apb_bridge #(
    parameter int SEL_LSB = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    ahbl_apb_bridge_if.slave bus
);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_DONE,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t      state_reg, state_next;
    logic        accept;
    logic        take;
    logic [7:0]  cnt_reg;
    logic [3:0]  sel_idx_reg;
    logic [31:0] paddr_reg;
    logic        pwrite_reg;
    logic [3:0]  pstrb_reg;
    logic [31:0] pwdata_reg;
    logic [31:0] hrdata_reg;
    logic        unused_bits;

    // Only NONSEQ/SEQ matter and sizes above a word are treated as a word.
    assign unused_bits = ^{bus.HTRANS[0], bus.HSIZE[2]};

    function automatic logic [3:0] write_strobe(input logic [1:0] size, input logic [1:0] lsb);
        logic [3:0] strb;
        case (size)
            2'b00:   strb = 4'b0001 << lsb;
            2'b01:   strb = lsb[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    assign accept = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
    // New address phases are only honoured once the previous one has completed
    // cleanly; an accept during the error tail is dropped.
    assign take   = accept & ((state_reg == S_IDLE) | (state_reg == S_DONE));

    // State register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_reg <= S_IDLE;
        else          state_reg <= state_next;
    end

    // Next-state decode.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (take) state_next = S_SETUP;
            S_SETUP:  state_next = S_ACCESS;
            S_ACCESS: begin
                if (bus.PREADY)                   state_next = bus.PSLVERR ? S_ERR1 : S_DONE;
                else if (cnt_reg == TIMEOUT_LAST) state_next = S_ERR1;
            end
            S_DONE:   state_next = take ? S_SETUP : S_IDLE;
            S_ERR1:   state_next = S_ERR2;
            S_ERR2:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from the state register plus the latched transfer.
    always_comb begin
        bus.HREADYOUT = 1'b1;
        bus.HRESP     = 1'b0;
        bus.PSEL      = '0;
        bus.PENABLE   = 1'b0;
        bus.PWDATA    = pwdata_reg;
        case (state_reg)
            S_SETUP: begin
                bus.HREADYOUT = 1'b0;
                bus.PSEL      = 16'h0001 << sel_idx_reg;
                bus.PWDATA    = bus.HWDATA;
            end
            S_ACCESS: begin
                bus.HREADYOUT = 1'b0;
                bus.PSEL      = 16'h0001 << sel_idx_reg;
                bus.PENABLE   = 1'b1;
            end
            S_ERR1: begin
                bus.HREADYOUT = 1'b0;
                bus.HRESP     = 1'b1;
            end
            S_ERR2: bus.HRESP = 1'b1;
            default: ;
        endcase
    end

    assign bus.PADDR  = paddr_reg;
    assign bus.PWRITE = pwrite_reg;
    assign bus.PSTRB  = pstrb_reg;
    assign bus.HRDATA = hrdata_reg;

    // Transfer latches: address-phase fields on accept, write data at the end
    // of SETUP, read data on a clean completion.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_idx_reg <= '0;
            paddr_reg   <= '0;
            pwrite_reg  <= 1'b0;
            pstrb_reg   <= '0;
            pwdata_reg  <= '0;
            hrdata_reg  <= '0;
        end else begin
            if (take) begin
                sel_idx_reg <= bus.HADDR[SEL_LSB +: 4];
                paddr_reg   <= bus.HADDR;
                pwrite_reg  <= bus.HWRITE;
                pstrb_reg   <= bus.HWRITE ? write_strobe(bus.HSIZE[1:0], bus.HADDR[1:0]) : 4'b0000;
            end
            if (state_reg == S_SETUP) pwdata_reg <= bus.HWDATA;
            if ((state_reg == S_ACCESS) && bus.PREADY && !bus.PSLVERR && !pwrite_reg)
                hrdata_reg <= bus.PRDATA;
        end
    end

    // Wait-state counter: cleared in SETUP, counts ACCESS cycles without PREADY.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)                                 cnt_reg <= '0;
        else if (state_reg == S_SETUP)                cnt_reg <= '0;
        else if ((state_reg == S_ACCESS) && !bus.PREADY) cnt_reg <= cnt_reg + 8'd1;
    end
endmodule

// File: tb/tb_ahbl_apb_bridge.sv
// Randomised scoreboard bench for ahbl_apb_bridge: the stimulus side predicts
// each transfer's APB fields and AHB response and queues them; a monitor pops
// and compares whenever the bridge completes a transfer.
module tb_ahbl_apb_bridge;
    localparam int TIMEOUT = 8;
    localparam int SEL_LSB = 16;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    ahbl_apb_bridge_if bus();
    assign bus.HREADY = bus.HREADYOUT;

    ahbl_apb_bridge #(.SEL_LSB(SEL_LSB), .TIMEOUT(TIMEOUT)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    typedef struct {
        int          id;
        logic [15:0] psel;
        logic [31:0] paddr;
        logic        pwrite;
        logic [3:0]  pstrb;
        logic [31:0] wdata;
        int          low;
        int          pen;
        logic        err;
        logic [31:0] hrdata;
    } exp_t;

    typedef struct {
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
    } rsp_t;

    exp_t        exp_q[$];
    rsp_t        rsp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          txn_id = 0;
    logic [31:0] hrdata_model = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic die(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired", name);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "stopped");
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (bus.HREADYOUT !== 1'b1) begin
            @(negedge HCLK);
            guard++;
            if (guard > 100) die("hreadyout_wait");
        end
    endtask

    // Predict the transfer, queue expectations, run address and data phase.
    // Returns at the negedge of the data phase (bridge in SETUP).
    task automatic start(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                         input logic [31:0] wdata, input int waits,
                         input logic [31:0] prdata, input logic slverr, output logic err);
        exp_t e;
        rsp_t r;
        int   access;
        wait_ready();
        e.id     = txn_id++;
        e.psel   = 16'h0001 << addr[SEL_LSB +: 4];
        e.paddr  = addr;
        e.pwrite = wr;
        e.wdata  = wdata;
        if (!wr)            e.pstrb = 4'b0000;
        else if (size == 0) e.pstrb = 4'b0001 << addr[1:0];
        else if (size == 1) e.pstrb = addr[1] ? 4'b1100 : 4'b0011;
        else                e.pstrb = 4'b1111;
        access = (waits < TIMEOUT) ? waits + 1 : TIMEOUT;
        e.err  = slverr || (waits >= TIMEOUT);
        e.pen  = access;
        e.low  = 1 + access + (e.err ? 1 : 0);
        if (!wr && !e.err) hrdata_model = prdata;
        e.hrdata = hrdata_model;
        r.waits  = waits;
        r.prdata = prdata;
        r.slverr = slverr;
        exp_q.push_back(e);
        rsp_q.push_back(r);
        err = e.err;
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HADDR  = addr;
        bus.HWRITE = wr;
        bus.HSIZE  = size;
        @(negedge HCLK);
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HADDR  = $urandom;
        bus.HWRITE = 1'($urandom);
        bus.HWDATA = wdata;
    endtask

    task automatic issue(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                         input logic [31:0] wdata, input int waits,
                         input logic [31:0] prdata, input logic slverr);
        logic err;
        start(addr, wr, size, wdata, waits, prdata, slverr, err);
        @(negedge HCLK);
        bus.HWDATA = $urandom;
        if (err) begin
            wait_ready();
            // Sometimes offer a new transfer during the error tail; it must be dropped.
            if ($urandom_range(0, 1) == 1) begin
                bus.HSEL   = 1'b1;
                bus.HTRANS = 2'b10;
                bus.HADDR  = 32'h6000_0000 | 32'($urandom_range(0, 32'h0FFF_FFFF));
            end
            @(negedge HCLK);
            bus.HSEL   = 1'b0;
            bus.HTRANS = 2'b00;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 2))
                0:       begin bus.HSEL = 1'b0; bus.HTRANS = 2'b10; end
                1:       begin bus.HSEL = 1'b1; bus.HTRANS = 2'b00; end
                default: begin bus.HSEL = 1'b1; bus.HTRANS = 2'b01; end
            endcase
            bus.HADDR  = $urandom;
            bus.HWRITE = 1'($urandom);
            @(negedge HCLK);
        end
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
    endtask

    // APB peripheral: answers each SETUP with the next queued response.
    initial begin
        rsp_t cur;
        int   acc;
        cur = '{0, 32'h0, 1'b0};
        acc = 0;
        bus.PREADY  = 1'b0;
        bus.PRDATA  = '0;
        bus.PSLVERR = 1'b0;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                bus.PREADY  = 1'b0;
                bus.PSLVERR = 1'b0;
                acc = 0;
            end else if (bus.PSEL != 0 && !bus.PENABLE) begin
                n_cmp++;
                if (rsp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_setup: got PSEL=0x%0h PADDR=0x%0h, required no access", bus.PSEL, bus.PADDR);
                    cur = '{0, 32'h0, 1'b0};
                end else begin
                    cur = rsp_q.pop_front();
                end
                acc = 0;
                bus.PREADY  = 1'b0;
                bus.PSLVERR = 1'b0;
                bus.PRDATA  = $urandom;
            end else if (bus.PSEL != 0 && bus.PENABLE) begin
                bus.PREADY  = (acc == cur.waits);
                bus.PSLVERR = bus.PREADY ? cur.slverr : 1'($urandom);
                bus.PRDATA  = bus.PREADY ? cur.prdata : $urandom;
                acc++;
            end else begin
                bus.PREADY  = 1'($urandom);
                bus.PSLVERR = 1'($urandom);
                bus.PRDATA  = $urandom;
            end
        end
    end

    // Monitor: APB fields while PSEL is up, AHB response when HREADYOUT returns.
    initial begin
        int   low;
        int   pen;
        logic err1;
        exp_t e;
        low = 0;
        pen = 0;
        err1 = 1'b0;
        forever begin
            @(negedge HCLK);
            #2;
            if (!HRESETn) begin
                low = 0;
                pen = 0;
                err1 = 1'b0;
            end else begin
                if (bus.PENABLE) check("penable_without_psel", bus.PSEL != 0, 1'b1);
                if (bus.PSEL != 0) begin
                    if (exp_q.size() != 0) begin
                        e = exp_q[0];
                        check("apb_fields", {bus.PSEL, bus.PADDR, bus.PWRITE, bus.PSTRB},
                                            {e.psel, e.paddr, e.pwrite, e.pstrb});
                        if (e.pwrite) check("pwdata", bus.PWDATA, e.wdata);
                    end
                    if (bus.PENABLE) pen++;
                end
                if (!bus.HREADYOUT) begin
                    low++;
                    if (bus.HRESP) begin
                        err1 = 1'b1;
                        check("err1_apb_idle", {bus.PSEL, bus.PENABLE}, 17'h0);
                    end
                end else if (low > 0) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_response: got HRESP=%0b after %0d wait cycles, required none", bus.HRESP, low);
                    end else begin
                        e = exp_q.pop_front();
                        check("hresp", bus.HRESP, e.err);
                        check("err1_phase", err1, e.err);
                        check("hreadyout_low_cycles", low, e.low);
                        check("penable_cycles", pen, e.pen);
                        check("hrdata", bus.HRDATA, e.hrdata);
                        check("resp_apb_idle", {bus.PSEL, bus.PENABLE}, 17'h0);
                        $display("txn %0d: %s addr=0x%08h strb=%b err=%0b waits=%0d hrdata=0x%08h",
                                 e.id, e.pwrite ? "WR" : "RD", e.paddr, e.pstrb, bus.HRESP, low, bus.HRDATA);
                    end
                    low = 0;
                    pen = 0;
                    err1 = 1'b0;
                end else begin
                    check("idle_outputs", {bus.HRESP, bus.PSEL, bus.PENABLE}, 18'h0);
                end
            end
        end
    end

    initial begin
        #1000000;
        die("global_time_limit");
    end

    initial begin
        logic        err;
        logic [31:0] r;
        logic [31:0] addr;
        logic [2:0]  size;
        int          k;
        int          waits;
        int          guard;

        bus.HSEL   = 1'b0;
        bus.HADDR  = '0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = 3'd0;
        bus.HWDATA = '0;
        HRESETn    = 1'b0;
        repeat (3) @(negedge HCLK);
        #2;
        check("reset_values",
              {bus.HREADYOUT, bus.HRESP, bus.HRDATA, bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWRITE, bus.PSTRB},
              {1'b1, 1'b0, 32'h0, 16'h0, 1'b0, 32'h0, 1'b0, 4'h0});
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);

        // Directed cases
        issue(32'h6003_0010, 1'b1, 3'd2, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
        idle(2);
        issue(32'h6005_0004, 1'b0, 3'd2, $urandom, 3, 32'h1234_5678, 1'b0);
        idle(1);
        issue(32'h6000_0003, 1'b1, 3'd0, 32'hAA00_0000, 0, 32'h0, 1'b0);
        issue(32'h6000_0002, 1'b1, 3'd1, 32'hBBCC_0000, 1, 32'h0, 1'b0);
        idle(1);
        issue(32'h600F_0008, 1'b0, 3'd2, $urandom, 0, 32'h5555_AAAA, 1'b1);
        issue(32'h6001_0000, 1'b1, 3'd2, 32'h0102_0304, 0, 32'h0, 1'b0);
        issue(32'h6007_0020, 1'b0, 3'd2, $urandom, 50, 32'h7777_7777, 1'b0);
        idle(1);
        issue(32'h6002_0040, 1'b0, 3'd2, $urandom, TIMEOUT - 1, 32'hCAFE_F00D, 1'b0);
        issue(32'h6004_0100, 1'b1, 3'd2, 32'h1111_2222, 0, 32'h0, 1'b0);
        issue(32'h6004_0104, 1'b0, 3'd2, $urandom, 0, 32'h3333_4444, 1'b0);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b00;
        @(negedge HCLK);
        idle(2);

        // Randomised traffic
        for (int n = 0; n < 300; n++) begin
            idle($urandom_range(0, 2));
            r    = $urandom;
            addr = {4'h6, r[27:0]};
            size = 3'($urandom_range(0, 2));
            if (size == 3'd1) addr[0] = 1'b0;
            if (size == 3'd2) addr[1:0] = 2'b00;
            k = $urandom_range(0, 9);
            if (k < 7)       waits = $urandom_range(0, 3);
            else if (k == 7) waits = TIMEOUT - 1;
            else if (k == 8) waits = TIMEOUT;
            else             waits = TIMEOUT + 4;
            issue(addr, 1'($urandom), size, $urandom, waits, $urandom, ($urandom_range(0, 7) == 0));
        end

        // Reset asserted in the middle of an ACCESS phase
        start(32'h6009_0000, 1'b0, 3'd2, $urandom, 100, 32'h0, 1'b0, err);
        @(negedge HCLK);
        #2;
        check("in_access_before_reset", bus.PENABLE, 1'b1);
        HRESETn = 1'b0;
        #1;
        check("reset_mid_access",
              {bus.PSEL, bus.PENABLE, bus.HREADYOUT, bus.HRESP, bus.HRDATA},
              {16'h0, 1'b0, 1'b1, 1'b0, 32'h0});
        repeat (2) @(negedge HCLK);
        exp_q.delete();
        rsp_q.delete();
        hrdata_model = '0;
        #1;
        HRESETn = 1'b1;
        @(negedge HCLK);
        issue(32'h600A_0004, 1'b0, 3'd2, $urandom, 1, 32'h0BAD_CAFE, 1'b0);
        issue(32'h600A_0001, 1'b1, 3'd0, 32'h0000_5A00, 0, 32'h0, 1'b0);

        guard = 0;
        while (exp_q.size() != 0) begin
            @(negedge HCLK);
            guard++;
            if (guard > 200) die("drain_wait");
        end
        repeat (3) @(negedge HCLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ahbl_apb_bridge.md
Name: ahbl_apb_bridge

Overview:
AHB-Lite slave to APB4 master bridge. It occupies the 256MB page at 0x6 of the AHB-Lite splitter and feeds up to 16 APB peripherals. Each AHB transfer becomes exactly one APB SETUP/ACCESS sequence, with a registered AHB response and a bounded wait timeout.

Parameters:
SEL_LSB, 16, LSB of the 4-bit HADDR field that selects the APB slave (PSEL index = HADDR[SEL_LSB+3:SEL_LSB]).
TIMEOUT, 255, maximum ACCESS cycles without PREADY before an error abort (1..255).

Ports:
HCLK  in  1  clock
HRESETn  in  1  reset
HSEL  in  1  AHB slave select from splitter
HADDR  in  32  AHB address
HTRANS  in  2  AHB transfer type; only bit 1 is used
HWRITE  in  1  AHB write
HSIZE  in  3  AHB size (byte/half/word)
HWDATA  in  32  AHB write data, valid in data phase
HREADY  in  1  bus HREADY (splitter mux output)
HREADYOUT  out  1  slave ready
HRESP  out  1  slave error response
HRDATA  out  32  read data
PSEL  out  16  one-hot APB select
PENABLE  out  1  APB enable
PADDR  out  32  APB address
PWRITE  out  1  APB write
PWDATA  out  32  APB write data
PSTRB  out  4  APB write strobes
PREADY  in  1  muxed APB ready
PRDATA  in  32  muxed APB read data
PSLVERR  in  1  muxed APB error

Behaviour:
- Reset is HRESETn, asynchronous, active-low; clock is HCLK. Reset values: state IDLE, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PSTRB=0, HREADYOUT=1, HRESP=0, HRDATA=0, timeout counter=0.
- Accept: a transfer is accepted when HSEL & HTRANS[1] & HREADY. This applies in IDLE or DONE. On accept, latch HADDR, HWRITE, HSIZE and the PSEL index, and go to SETUP. IDLE/BUSY transfers are ignored; the bridge stays in IDLE with HREADYOUT=1 and HRESP=0.
- PSTRB for writes: byte = 1<<HADDR[1:0]; half = 0011 or 1100 by HADDR[1]; word = 1111. PSTRB is 0000 for reads.
- SETUP (1 cycle): PSEL[idx]=1, PENABLE=0, PADDR/PWRITE/PSTRB valid, HREADYOUT=0.
  - PWDATA is driven combinationally from HWDATA in SETUP and captured into a register at the end of SETUP.
  - In ACCESS, PWDATA comes from that register, so it is stable through ACCESS.
  - Then go to ACCESS.
- ACCESS: PSEL and PENABLE=1, all P* outputs stable, HREADYOUT=0. The counter increments each cycle PREADY=0.
  - PREADY=1 and PSLVERR=0: for reads, HRDATA <= PRDATA. Go to DONE.
  - PREADY=1 and PSLVERR=1: go to ERR1.
  - Counter reaches TIMEOUT with PREADY=0: go to ERR1. This aborts the access (PSEL/PENABLE drop) and leaves HRDATA unchanged.
- DONE (1 cycle): PSEL=0, PENABLE=0, HREADYOUT=1, HRESP=0.
  - A new accept here goes directly to SETUP (back-to-back).
  - Otherwise go to IDLE.
- ERR1: HREADYOUT=0, HRESP=1, P* deasserted. Then ERR2.
- ERR2: HREADYOUT=1, HRESP=1. An accept here is ignored (the master cancels on error). Go to IDLE.
- Minimum data-phase latency (PREADY=1 on the first ACCESS cycle): addr T0, SETUP T1, ACCESS T2, DONE T3. HREADYOUT is low T1–T2 and high at T3.
- Between accesses PADDR, PWRITE and PSTRB hold their last values. PENABLE is never high without PSEL.
- Reset mid-transfer returns all outputs to reset values immediately. No APB completion is awaited.

Test Plan:
- Word write 0xDEADBEEF to 0x6003_0010, PREADY=1: PSEL=0x0008, PADDR=0x6003_0010, PWDATA=0xDEADBEEF, PSTRB=1111, PENABLE high in exactly 1 cycle, HREADYOUT low 2 cycles then high.
- Read of 0x6005_0004, PREADY low 3 ACCESS cycles then high with PRDATA=0x1234_5678: HRDATA=0x1234_5678 in DONE, HRESP=0, HREADYOUT low 5 cycles.
- Byte write to 0x6000_0003 and halfword write to 0x6000_0002: PSTRB=1000 and 1100 respectively.
- Read with PSLVERR=1 on completion: ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); next transfer proceeds normally.
- PREADY held low, TIMEOUT=8: abort after 8 ACCESS cycles, PSEL/PENABLE drop, two-cycle error response.
- Back-to-back write then read, plus an HTRANS=IDLE cycle: second SETUP follows DONE directly; IDLE produces no PSEL. Asserting HRESETn low during ACCESS: PSEL=0, PENABLE=0, HREADYOUT=1 immediately.
